// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Holds the FSM state enum, the supported opcodes, the ALUControl, ALUOp,
// ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings, and the ImmSrc decode.
// Ports: none (package).
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format selected purely from the opcode; formats without an
  // immediate (R-type, unsupported) fall back to the I encoding.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master: controller side (consumes IR fields, Zero, mem_ready; drives
//         the datapath controls and illegal_op).
// slave:  datapath side (the mirror image).
// With MULTICYCLE_PERF_EN defined the bundle also carries instr_retired.
interface multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       illegal_op;
`ifdef MULTICYCLE_PERF_EN
  logic [CNT_WIDTH-1:0] instr_retired;
`endif

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op
`ifdef MULTICYCLE_PERF_EN
    , output instr_retired
`endif
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op
`ifdef MULTICYCLE_PERF_EN
    , input instr_retired
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational ALUOp/funct decode to ALUControl.
// Ports: aluop (2), funct3 (3), op5 (IR[5]), funct7b5 (IR[30]) in;
//        alu_control (3) out.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // ALUOp/funct3 decode; sub only for R-type with funct7[5] set
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if ({op5, funct7b5} == 2'b11) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM (fetch/decode/execute/wb).
// Ports: clk, rst (async, active-high); bus (multicycle_ctrl_if.master)
//        carrying op/funct3/funct7b5/Zero/mem_ready in and all datapath
//        controls plus illegal_op out.
// Optional feature: MULTICYCLE_PERF_EN adds bus.instr_retired, a
// CNT_WIDTH-bit wrapping count of completed (non-illegal) instructions.
// Outputs are Moore decodes of the state, except PCWrite (uses Zero),
// FETCH's IRWrite/PCUpdate (wait on mem_ready) and ImmSrc (from op).
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  multicycle_ctrl_if.master bus
);

  state_t     state_r;
  state_t     next_s;
  logic       illegal_s;
  logic       adrsrc_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       pcupdate_s;
  logic       branch_s;
  logic [1:0] resultsrc_s;
  logic [1:0] alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;
  logic [2:0] alucontrol_s;

  alu_decoder u_alu_decoder (
    .aluop       (aluop_s),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (alucontrol_s)
  );

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; illegal_op flags an unsupported opcode in DECODE
  always_comb begin
    next_s    = state_r;
    illegal_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (bus.mem_ready) next_s = DECODE;
        else               next_s = FETCH;
      end
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: next_s = MEMADR;
          OP_RTYPE:          next_s = EXECR;
          OP_ITYPE:          next_s = EXECI;
          OP_BRANCH:         next_s = BEQ;
          OP_JAL:            next_s = JAL;
          default: begin
            next_s    = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (bus.op[5]) next_s = MEMWRITE;
        else           next_s = MEMREAD;
      end
      MEMREAD: begin
        if (bus.mem_ready) next_s = MEMWB;
        else               next_s = MEMREAD;
      end
      MEMWRITE: begin
        if (bus.mem_ready) next_s = FETCH;
        else               next_s = MEMWRITE;
      end
      MEMWB:   next_s = FETCH;
      EXECR:   next_s = ALUWB;
      EXECI:   next_s = ALUWB;
      ALUWB:   next_s = FETCH;
      BEQ:     next_s = FETCH;
      JAL:     next_s = ALUWB;
      default: next_s = FETCH;
    endcase
  end

  // Per-state control decode, before the reset gate
  always_comb begin
    adrsrc_s    = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    pcupdate_s  = 1'b0;
    branch_s    = 1'b0;
    resultsrc_s = RES_ALUOUT;
    alusrca_s   = SRCA_PC;
    alusrcb_s   = SRCB_RS2;
    aluop_s     = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        // PC+4 is computed every fetch cycle but only latched once ready
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALURESULT;
        irwrite_s   = bus.mem_ready;
        pcupdate_s  = bus.mem_ready;
      end
      DECODE: begin
        // branch/jump target precomputed into ALUOut
        alusrca_s = SRCA_OLDPC;
        alusrcb_s = SRCB_IMM;
      end
      MEMADR: begin
        alusrca_s = SRCA_RS1;
        alusrcb_s = SRCB_IMM;
      end
      MEMREAD: adrsrc_s = 1'b1;
      MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECR: begin
        alusrca_s = SRCA_RS1;
        aluop_s   = ALUOP_FUNCT;
      end
      EXECI: begin
        alusrca_s = SRCA_RS1;
        alusrcb_s = SRCB_IMM;
        aluop_s   = ALUOP_FUNCT;
      end
      ALUWB: regwrite_s = 1'b1;
      BEQ: begin
        alusrca_s = SRCA_RS1;
        aluop_s   = ALUOP_SUB;
        branch_s  = 1'b1;
      end
      JAL: begin
        alusrca_s  = SRCA_OLDPC;
        alusrcb_s  = SRCB_FOUR;
        pcupdate_s = 1'b1;
      end
      default: begin
        adrsrc_s = 1'b0;
      end
    endcase
  end

  // Reset gate: while rst is high every control except ImmSrc reads 0
  always_comb begin
    if (rst) begin
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = 3'b000;
      bus.illegal_op = 1'b0;
    end else begin
      bus.PCWrite    = pcupdate_s | (branch_s & bus.Zero);
      bus.AdrSrc     = adrsrc_s;
      bus.MemWrite   = memwrite_s;
      bus.IRWrite    = irwrite_s;
      bus.RegWrite   = regwrite_s;
      bus.ResultSrc  = resultsrc_s;
      bus.ALUSrcA    = alusrca_s;
      bus.ALUSrcB    = alusrcb_s;
      bus.ALUControl = alucontrol_s;
      bus.illegal_op = illegal_s;
    end
  end

  // Immediate format follows the opcode in every state, reset included
  always_comb begin
    bus.ImmSrc = imm_src(bus.op);
  end

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_WIDTH-1:0] retired_r;
  logic                 retire_s;

  // An instruction retires on the edge that returns the FSM to FETCH from
  // a completing state; the DECODE->FETCH path of an illegal op is excluded
  always_comb begin
    retire_s = 1'b0;
    if (next_s == FETCH) begin
      case (state_r)
        MEMWB, MEMWRITE, ALUWB, BEQ: retire_s = 1'b1;
        default:                     retire_s = 1'b0;
      endcase
    end else begin
      retire_s = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= {CNT_WIDTH{1'b0}};
    end else if (retire_s) begin
      retired_r <= retired_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.instr_retired = retired_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus drives one cycle at a
// time and queues the hand-computed control vector for that cycle; the
// monitor pops and compares on the falling edge.
// Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                 ResultSrc[2], ALUSrcA[2], ALUSrcB[2], ALUControl[3],
//                 ImmSrc[2], illegal_op}
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cycles = 0;

  string       nq[$];
  logic [16:0] eq[$];
  int          cq[$];

  string       cur_n;
  logic [16:0] cur_e;
  int          cur_c;
  logic [16:0] act;

  multicycle_ctrl_if #(.CNT_WIDTH(32)) bus ();

  multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.ImmSrc, bus.illegal_op};

  function automatic logic [16:0] mk(
    input logic pcw, input logic adr, input logic mw, input logic irw,
    input logic rw, input logic [1:0] rs, input logic [1:0] a,
    input logic [1:0] b, input logic [2:0] alu, input logic [1:0] imm,
    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  // One stimulus cycle: drive inputs after the rising edge and queue the
  // vector expected before the next rising edge (cnt < 0: counter unchecked)
  task automatic cyc(input string nm, input logic r, input logic [6:0] o,
                     input logic [2:0] f3, input logic f7, input logic z,
                     input logic mr, input logic [16:0] e, input int cnt);
    rst          = r;
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = z;
    bus.mem_ready = mr;
    nq.push_back(nm);
    eq.push_back(e);
    cq.push_back(cnt);
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Monitor: compare each queued expectation; also bounds the run
  always @(negedge clk) begin
    cycles = cycles + 1;
    if (eq.size() > 0) begin
      cur_n = nq.pop_front();
      cur_e = eq.pop_front();
      cur_c = cq.pop_front();
      total = total + 1;
      if (act !== cur_e) begin
        bad = bad + 1;
        $display("FAIL %s: got %b want %b", cur_n, act, cur_e);
      end
`ifdef MULTICYCLE_PERF_EN
      if (cur_c >= 0) begin
        total = total + 1;
        if (bus.instr_retired !== 32'(cur_c)) begin
          bad = bad + 1;
          $display("FAIL %s.instr_retired: got %0d want %0d", cur_n,
                   bus.instr_retired, cur_c);
        end
      end
`endif
    end else if (done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (cycles > 2000) begin
      bad = bad + 1;
      $display("FAIL watchdog: got %0d cycles want <= 2000", cycles);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // 1. reset held 3 cycles: all zero except ImmSrc (sw -> S)
    for (int i = 0; i < 3; i++)
      cyc("rst_hold", 1'b1, SW, 3'b000, 1'b0, 1'b0, 1'b1,
          mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), 0);
    // 2. lw: 5 cycles, RegWrite/ResultSrc=01 only in MEMWB
    cyc("lw_fetch", 1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 0);
    cyc("lw_dec",   1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("lw_adr",   1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), -1);
    cyc("lw_rd",    1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("lw_wb",    1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0), 0);
    // 3. sub (f7b5=1), add (f7b5=0), slti, addi with IR[30]=1, or
    cyc("sub_fetch", 1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 1);
    cyc("sub_dec",   1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("sub_ex",    1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0), -1);
    cyc("sub_wb",    1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("add_fetch", 1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 2);
    cyc("add_dec",   1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("add_ex",    1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0), -1);
    cyc("add_wb",    1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("slti_fetch",1'b0, IT, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 3);
    cyc("slti_dec",  1'b0, IT, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("slti_ex",   1'b0, IT, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0), -1);
    cyc("slti_wb",   1'b0, IT, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("addi_fetch",1'b0, IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 4);
    cyc("addi_dec",  1'b0, IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("addi_ex",   1'b0, IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), -1);
    cyc("addi_wb",   1'b0, IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("or_fetch",  1'b0, RT, 3'b110, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 5);
    cyc("or_dec",    1'b0, RT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("or_ex",     1'b0, RT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0), -1);
    cyc("or_wb",     1'b0, RT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    // 4. beq taken (Zero=1 throughout), then not taken; 3 cycles each
    cyc("beq1_fetch",1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0), 6);
    cyc("beq1_dec",  1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), -1);
    cyc("beq1_br",   1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), -1);
    cyc("beq0_fetch",1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0), 7);
    cyc("beq0_dec",  1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), -1);
    cyc("beq0_br",   1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), -1);
    // jal: 4 cycles, PC loaded in JAL, link written in ALUWB
    cyc("jal_fetch", 1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b11,0), 8);
    cyc("jal_dec",   1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0), -1);
    cyc("jal_jal",   1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0), -1);
    cyc("jal_wb",    1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b11,0), -1);
    // 5. sw with a fetch stall and a 2-cycle write stall
    cyc("sw_fstall", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0), 9);
    cyc("sw_fetch",  1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b01,0), 9);
    cyc("sw_dec",    1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0), -1);
    cyc("sw_adr",    1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0), -1);
    cyc("sw_wr0",    1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), -1);
    cyc("sw_wr1",    1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), -1);
    cyc("sw_wr2",    1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), 9);
    // 6. illegal opcode: 2 cycles, not counted
    cyc("ill_fetch", 1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 10);
    cyc("ill_dec",   1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,1), 10);
    // lw aborted by reset in MEMWB: no RegWrite, counter cleared
    cyc("ab_fetch",  1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 10);
    cyc("ab_dec",    1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    cyc("ab_adr",    1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), -1);
    cyc("ab_rd",     1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), -1);
    cyc("ab_rst",    1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), 0);
    cyc("ab_refetch",1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), 0);
    cyc("ab_dec2",   1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), -1);
    done = 1'b1;
  end

endmodule
